// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the SPARC instruction fetch stage:
//   - fetch_state_e   : fetch FSM state encoding
//   - RAM_READ_WORD   : RAM opcode for an instruction (ld word) read
//   - PC_INCR         : sequential PC/NPC increment (one 32-bit word)
//   - is_misaligned() : word-alignment test on a fetch address
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [5:0]  RAM_READ_WORD = 6'b000000;
  localparam logic [31:0] PC_INCR       = 32'd4;

  // A fetch address must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory read bus between the fetch unit and RAM.
//   mem_addr   : fetch address (fetch unit -> RAM)
//   RAM_enable : read request, held until MFC (fetch unit -> RAM)
//   RAM_OpCode : RAM operation code (fetch unit -> RAM)
//   MFC        : memory function complete (RAM -> fetch unit)
//   mem_data   : read data, valid while MFC=1 (RAM -> fetch unit)
// Modports: master = fetch unit side, slave = RAM side.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;

  logic [31:0] mem_addr;
  logic        RAM_enable;
  logic [5:0]  RAM_OpCode;
  logic        MFC;
  logic [31:0] mem_data;

  modport master (
    output mem_addr,
    output RAM_enable,
    output RAM_OpCode,
    input  MFC,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  RAM_enable,
    input  RAM_OpCode,
    output MFC,
    output mem_data
  );

endinterface

// File: rtl/instr_fetch_unit_pc_npc_reg.sv
// -----------------------------------------------------------------------------
// pc_npc_reg
// SPARC PC/NPC register pair with delayed-branch update.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   advance_i    : current instruction retired; PC <= NPC
//   taken_i      : with advance_i, control transfer taken (NPC <= target_i)
//   target_i     : branch target address
//   pc_o, npc_o  : current PC and next PC
// -----------------------------------------------------------------------------
module pc_npc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance_i,
  input  logic        taken_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o
);
  import instr_fetch_unit_pkg::*;

  logic [31:0] pc_q,  pc_d;
  logic [31:0] npc_q, npc_d;

  // Next-state: on retire the old NPC becomes PC, so a taken branch still
  // executes its delay slot before reaching the target. Wraps mod 2^32.
  always_comb begin
    pc_d  = pc_q;
    npc_d = npc_q;
    if (advance_i) begin
      pc_d = npc_q;
      if (taken_i) begin
        npc_d = target_i;
      end else begin
        npc_d = npc_q + PC_INCR;
      end
    end else begin
      pc_d  = pc_q;
      npc_d = npc_q;
    end
  end

  // PC/NPC state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      npc_q <= RESET_PC + PC_INCR;
    end else begin
      pc_q  <= pc_d;
      npc_q <= npc_d;
    end
  end

  assign pc_o  = pc_q;
  assign npc_o = npc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// SPARC fetch stage: issues word reads at PC, waits for MFC, latches IR_Out
// and holds it until exec_done, then advances PC/NPC (delayed branch).
// Misaligned PC or MFC timeout raises a sticky fetch_fault (terminal state).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   mem             : memory read bus (master side: mem_addr, RAM_enable,
//                     RAM_OpCode out; MFC, mem_data in)
//   exec_done       : 1-cycle pulse, current IR_Out executed
//   branch_taken    : qualifies exec_done, control transfer taken
//   branch_target   : target address sampled with exec_done
//   stall           : hold in IDLE, no new fetch
//   IR_Out          : instruction register
//   ir_valid        : IR_Out holds a fetched, unexecuted instruction
//   PC, NPC         : program counter pair
//   fetch_fault     : sticky misalignment / timeout flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned MFC_TIMEOUT   = 255,
  parameter logic [5:0]  RAM_READ_WORD = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  instr_fetch_unit_if.master mem,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic [31:0] IR_Out,
  output logic        ir_valid,
  output logic [31:0] PC,
  output logic [31:0] NPC,
  output logic        fetch_fault
);
  import instr_fetch_unit_pkg::*;

  // Counter holds the number of WAIT cycles already spent without MFC; the
  // fault fires at the end of the MFC_TIMEOUT-th such cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MFC_TIMEOUT - 1);

  fetch_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         fault_q, fault_d;
  logic [31:0]  ir_q, ir_d;
  logic         ir_valid_q;
  logic         ram_en_q;
  logic [5:0]   opcode_q;
  logic [31:0]  addr_q, addr_d;
  logic         advance_s;
  logic         req_next_s;
  logic [31:0]  pc_s;
  logic [31:0]  npc_s;

  pc_npc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_npc (
    .clk       (clk),
    .reset     (reset),
    .advance_i (advance_s),
    .taken_i   (branch_taken),
    .target_i  (branch_target),
    .pc_o      (pc_s),
    .npc_o     (npc_s)
  );

  // exec_done only retires an instruction while it is held in HOLD.
  assign advance_s = (state_q == ST_HOLD) && exec_done;

  // Next-state, timeout counter, fault flag and IR capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (stall) begin
          state_d = ST_IDLE;
        end else if (is_misaligned(pc_s)) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem.MFC) begin
          ir_d    = mem.mem_data;
          state_d = ST_HOLD;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (exec_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        // An unreachable encoding is treated as a fault and parked.
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
    endcase
  end

  // The read request is active in REQ and WAIT; outputs are registered off
  // the next state so they line up with the state they describe.
  assign req_next_s = (state_d == ST_REQ) || (state_d == ST_WAIT);

  // Fetch address is captured from PC as the request is launched.
  always_comb begin
    if (state_q == ST_IDLE && state_d == ST_REQ) begin
      addr_d = pc_s;
    end else begin
      addr_d = addr_q;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      fault_q    <= 1'b0;
      ir_q       <= 32'h0000_0000;
      ir_valid_q <= 1'b0;
      ram_en_q   <= 1'b0;
      opcode_q   <= 6'd0;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      ir_q       <= ir_d;
      ir_valid_q <= (state_d == ST_HOLD);
      ram_en_q   <= req_next_s;
      opcode_q   <= req_next_s ? RAM_READ_WORD : 6'd0;
      addr_q     <= addr_d;
    end
  end

  assign mem.mem_addr   = addr_q;
  assign mem.RAM_enable = ram_en_q;
  assign mem.RAM_OpCode = opcode_q;
  assign IR_Out         = ir_q;
  assign ir_valid       = ir_valid_q;
  assign PC             = pc_s;
  assign NPC            = npc_s;
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed self-checking bench for instr_fetch_unit.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] IR_Out;
  logic        ir_valid;
  logic [31:0] PC;
  logic [31:0] NPC;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .MFC_TIMEOUT   (255),
    .RAM_READ_WORD (6'b000000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem           (bus.master),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .IR_Out        (IR_Out),
    .ir_valid      (ir_valid),
    .PC            (PC),
    .NPC           (NPC),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a read request, record it, answer with MFC one cycle
  // after RAM_enable is seen.
  task automatic do_fetch(input logic [31:0] data, output logic [31:0] addr,
                          output logic [5:0] op, output bit seen);
    seen = 1'b0;
    addr = 32'h0;
    op   = 6'h3f;
    for (int i = 0; i < 20; i++) begin
      if (bus.RAM_enable === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (seen) begin
      addr = bus.mem_addr;
      op   = bus.RAM_OpCode;
      tick();
      bus.MFC      = 1'b1;
      bus.mem_data = data;
      tick();
      bus.MFC      = 1'b0;
      bus.mem_data = 32'h0;
    end
  endtask

  task automatic do_exec(input logic taken, input logic [31:0] target);
    exec_done     = 1'b1;
    branch_taken  = taken;
    branch_target = target;
    tick();
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({PC, NPC} !== {32'h0, 32'h4}) begin
      errors++;
      $display("FAIL reset_pc_npc: got PC=%h NPC=%h expected PC=0 NPC=4", PC, NPC);
    end
    checks++;
    if ({IR_Out, ir_valid, fetch_fault} !== {32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ir: got IR=%h v=%b f=%b expected 0/0/0", IR_Out, ir_valid, fetch_fault);
    end
    checks++;
    if ({bus.RAM_enable, bus.RAM_OpCode, bus.mem_addr} !== {1'b0, 6'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset_bus: got en=%b op=%h addr=%h expected 0/0/0",
               bus.RAM_enable, bus.RAM_OpCode, bus.mem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_fetch();
    logic [31:0] addr;
    logic [5:0]  op;
    bit          seen;
    logic [31:0] ir_before;
    bit          ok;
    apply_reset();
    do_fetch(32'h8200_4001, addr, op, seen);
    checks++;
    if (seen !== 1'b1 || addr !== 32'h0 || op !== 6'd0) begin
      errors++;
      $display("FAIL first_req: got seen=%b addr=%h op=%h expected 1/0/0", seen, addr, op);
    end
    checks++;
    if ({IR_Out, ir_valid} !== {32'h8200_4001, 1'b1}) begin
      errors++;
      $display("FAIL first_ir: got IR=%h v=%b expected 82004001/1", IR_Out, ir_valid);
    end
    checks++;
    if ({PC, NPC, bus.RAM_enable} !== {32'h0, 32'h4, 1'b0}) begin
      errors++;
      $display("FAIL first_pc: got PC=%h NPC=%h en=%b expected 0/4/0", PC, NPC, bus.RAM_enable);
    end
    // IR must stay put in HOLD even with bus activity; no new request.
    ir_before = IR_Out;
    ok = 1'b1;
    bus.mem_data = 32'hDEAD_BEEF;
    bus.MFC = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (IR_Out !== 32'h8200_4001 || ir_valid !== 1'b1 || bus.RAM_enable !== 1'b0) ok = 1'b0;
    end
    bus.MFC = 1'b0;
    bus.mem_data = 32'h0;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL hold_stable: got IR=%h v=%b en=%b expected %h/1/0",
               IR_Out, ir_valid, bus.RAM_enable, ir_before);
    end
    do_exec(1'b0, 32'h0);
    checks++;
    if ({PC, NPC, ir_valid} !== {32'h4, 32'h8, 1'b0}) begin
      errors++;
      $display("FAIL first_exec: got PC=%h NPC=%h v=%b expected 4/8/0", PC, NPC, ir_valid);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] addr;
    logic [5:0]  op;
    bit          seen;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      do_fetch(32'h0100_0000 + 32'(k), addr, op, seen);
      checks++;
      if (seen !== 1'b1 || addr !== 32'(4 * k) || IR_Out !== 32'h0100_0000 + 32'(k)) begin
        errors++;
        $display("FAIL seq_fetch%0d: got seen=%b addr=%h IR=%h expected 1/%h/%h",
                 k, seen, addr, IR_Out, 32'(4 * k), 32'h0100_0000 + 32'(k));
      end
      do_exec(1'b0, 32'h0);
    end
    checks++;
    if ({PC, NPC} !== {32'd12, 32'd16}) begin
      errors++;
      $display("FAIL seq_pc: got PC=%h NPC=%h expected c/10", PC, NPC);
    end
  endtask

  task automatic test_delayed_branch();
    logic [31:0] addr;
    logic [5:0]  op;
    bit          seen;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      do_fetch(32'h0, addr, op, seen);
      do_exec(1'b0, 32'h0);
    end
    checks++;
    if ({PC, NPC} !== {32'h10, 32'h14}) begin
      errors++;
      $display("FAIL br_setup: got PC=%h NPC=%h expected 10/14", PC, NPC);
    end
    do_fetch(32'h1080_0010, addr, op, seen);
    // branch_taken alone, without exec_done, must not move anything
    branch_taken = 1'b1;
    branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    do_exec(1'b1, 32'h100);
    checks++;
    if ({PC, NPC} !== {32'h14, 32'h100}) begin
      errors++;
      $display("FAIL br_taken: got PC=%h NPC=%h expected 14/100", PC, NPC);
    end
    do_fetch(32'h0, addr, op, seen);
    checks++;
    if (seen !== 1'b1 || addr !== 32'h14) begin
      errors++;
      $display("FAIL br_slot_addr: got seen=%b addr=%h expected 1/14", seen, addr);
    end
    do_exec(1'b0, 32'h0);
    checks++;
    if ({PC, NPC} !== {32'h100, 32'h104}) begin
      errors++;
      $display("FAIL br_after_slot: got PC=%h NPC=%h expected 100/104", PC, NPC);
    end
    do_fetch(32'h0, addr, op, seen);
    checks++;
    if (seen !== 1'b1 || addr !== 32'h100) begin
      errors++;
      $display("FAIL br_target_addr: got seen=%b addr=%h expected 1/100", seen, addr);
    end
    do_exec(1'b0, 32'h0);
  endtask

  task automatic test_misaligned();
    logic [31:0] addr;
    logic [5:0]  op;
    bit          seen;
    bit          en_seen;
    apply_reset();
    do_fetch(32'h0, addr, op, seen);
    do_exec(1'b1, 32'h102);
    checks++;
    if ({PC, NPC, fetch_fault} !== {32'h4, 32'h102, 1'b0}) begin
      errors++;
      $display("FAIL mis_accept: got PC=%h NPC=%h f=%b expected 4/102/0", PC, NPC, fetch_fault);
    end
    do_fetch(32'h0, addr, op, seen);
    do_exec(1'b0, 32'h0);
    en_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.RAM_enable !== 1'b0) en_seen = 1'b1;
    end
    checks++;
    if ({PC, fetch_fault, ir_valid, en_seen} !== {32'h102, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mis_fault: got PC=%h f=%b v=%b en_pulse=%b expected 102/1/0/0",
               PC, fetch_fault, ir_valid, en_seen);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    apply_reset();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.RAM_enable === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    // 1 REQ cycle + 254 WAIT cycles: still waiting
    for (int i = 0; i < 255; i++) tick();
    checks++;
    if (seen !== 1'b1 || fetch_fault !== 1'b0 || bus.RAM_enable !== 1'b1) begin
      errors++;
      $display("FAIL to_early: got seen=%b f=%b en=%b expected 1/0/1", seen, fetch_fault, bus.RAM_enable);
    end
    tick();
    checks++;
    if ({fetch_fault, bus.RAM_enable, ir_valid} !== {1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL to_fault: got f=%b en=%b v=%b expected 1/0/0", fetch_fault, bus.RAM_enable, ir_valid);
    end
    // late MFC and exec_done in FAULT change nothing
    bus.MFC = 1'b1;
    bus.mem_data = 32'hCAFE_F00D;
    exec_done = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.MFC = 1'b0;
    exec_done = 1'b0;
    checks++;
    if ({fetch_fault, bus.RAM_enable, IR_Out, PC} !== {1'b1, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL to_stuck: got f=%b en=%b IR=%h PC=%h expected 1/0/0/0",
               fetch_fault, bus.RAM_enable, IR_Out, PC);
    end
    stall = 1'b1;
    apply_reset();
    checks++;
    if ({fetch_fault, PC, NPC} !== {1'b0, 32'h0, 32'h4}) begin
      errors++;
      $display("FAIL to_reset: got f=%b PC=%h NPC=%h expected 0/0/4", fetch_fault, PC, NPC);
    end
    stall = 1'b0;
  endtask

  task automatic test_stall_abort();
    bit en_seen;
    stall = 1'b1;
    apply_reset();
    en_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.RAM_enable !== 1'b0) en_seen = 1'b1;
    end
    do_exec(1'b1, 32'h400);
    checks++;
    if ({en_seen, PC, NPC} !== {1'b0, 32'h0, 32'h4}) begin
      errors++;
      $display("FAIL stall_idle: got en_pulse=%b PC=%h NPC=%h expected 0/0/4", en_seen, PC, NPC);
    end
    stall = 1'b0;
    tick();               // IDLE -> REQ
    tick();               // REQ -> WAIT
    checks++;
    if (bus.RAM_enable !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got en=%b expected 1", bus.RAM_enable);
    end
    stall = 1'b1;
    reset = 1'b1;
    bus.MFC = 1'b1;
    bus.mem_data = 32'h1234_5678;
    tick();
    reset = 1'b0;
    tick();
    tick();
    bus.MFC = 1'b0;
    bus.mem_data = 32'h0;
    checks++;
    if ({IR_Out, ir_valid, PC, bus.RAM_enable} !== {32'h0, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL abort: got IR=%h v=%b PC=%h en=%b expected 0/0/0/0",
               IR_Out, ir_valid, PC, bus.RAM_enable);
    end
    stall = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    stall         = 1'b0;
    bus.MFC       = 1'b0;
    bus.mem_data  = 32'h0;
    #1;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_delayed_branch();
    test_misaligned();
    test_timeout();
    test_stall_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential fetch stage directly upstream of the combinational control decoder.
- Holds the SPARC PC/NPC pair and issues word reads to RAM, handshaking on MFC.
- Latches the returned word into IR_Out and holds it stable until the execute side signals completion.
- Implements SPARC delayed-branch PC/NPC update and flags misaligned or timed-out fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset (NPC = RESET_PC+4)
MFC_TIMEOUT, 255, max cycles to wait for MFC before raising fault (8-bit counter)
RAM_READ_WORD, 6'b000000, RAM_OpCode driven for an instruction fetch (ld word)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
MFC  input  1  memory function complete from RAM
mem_data  input  32  RAM read data, valid while MFC=1
exec_done  input  1  1-cycle pulse: current IR_Out fully executed
branch_taken  input  1  qualifies exec_done: control transfer taken
branch_target  input  32  target address, sampled with exec_done
stall  input  1  hold in IDLE; no new fetch issued
mem_addr  output  32  fetch address (PC) to RAM/MAR path
RAM_enable  output  1  read request, held high until MFC
RAM_OpCode  output  6  RAM_READ_WORD while RAM_enable=1, else 0
IR_Out  output  32  instruction register
ir_valid  output  1  IR_Out holds a fetched, unexecuted instruction
PC  output  32  current PC
NPC  output  32  next PC
fetch_fault  output  1  sticky: misaligned fetch or MFC timeout

Behaviour:
- Clock is clk; reset is synchronous and active-high. With reset=1 at an edge: state=IDLE, PC=RESET_PC, NPC=RESET_PC+4, IR_Out=0, ir_valid=0, RAM_enable=0, RAM_OpCode=0, mem_addr=RESET_PC, fetch_fault=0, timeout counter=0.
- Reset mid-operation, including while waiting on MFC, aborts immediately with no IR update. A late MFC arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE:
  - stall=1: stay in IDLE.
  - PC[1:0]!=0: go to FAULT and set fetch_fault.
  - Otherwise go to REQ.
- REQ (1 cycle): RAM_enable=1, RAM_OpCode=RAM_READ_WORD, mem_addr=PC; counter cleared. Next state is WAIT.
- WAIT: RAM_enable held at 1.
  - MFC=1: IR_Out<=mem_data, ir_valid<=1, RAM_enable<=0, go to HOLD. Minimum MFC-to-ir_valid latency is 1 cycle.
  - Counter reaches MFC_TIMEOUT with no MFC: set fetch_fault, go to FAULT.
- HOLD: IR_Out is stable and no RAM request is made. On exec_done:
  - Always: PC<=NPC.
  - Not taken: NPC<=NPC+4 (mod 2^32, wraps silently).
  - Taken: NPC<=branch_target (delay slot executes at the old NPC).
  - Then ir_valid<=0 and go to IDLE.
- exec_done outside HOLD is ignored. branch_taken is meaningful only when exec_done=1.
- FAULT: terminal until reset. All outputs hold, except RAM_enable=0 and ir_valid=0.
- Misaligned branch_target is accepted into NPC; the fault is raised when it becomes PC at IDLE.
- Steady-state fetch with 1-cycle MFC: IDLE→REQ→WAIT→HOLD gives ir_valid 3 cycles after leaving IDLE.

Decomposition:
- Shared package (sparc_pkg): fetch FSM state enum; RAM opcode constants (RAM_READ_WORD); the PC increment constant 4.
- One natural sub-module, pc_npc_reg: PC/NPC pair with reset value, sequential increment and delayed-branch load. The FSM and timeout counter stay in instr_fetch_unit.

Test Plan:
- Reset, then MFC returns 1 cycle after RAM_enable with mem_data=32'h8200_4001 → RAM_enable asserted with mem_addr=0 and RAM_OpCode=0; IR_Out=32'h8200_4001, ir_valid=1; PC=0, NPC=4.
- Sequential flow: three fetch/exec_done cycles, not taken → fetch addresses 0, 4, 8; after the third, PC=12, NPC=16.
- Delayed branch: PC=0x10, NPC=0x14, exec_done with branch_taken=1 and branch_target=0x100 → PC=0x14, NPC=0x100. Next fetch is at 0x14, then at 0x100 after a non-taken exec_done.
- MFC timeout: MFC held at 0 → fetch_fault=1 after MFC_TIMEOUT cycles in WAIT; RAM_enable=0; state stuck until reset, then PC=RESET_PC.
- Misalignment: taken branch to 0x102 → after delay-slot exec_done, IDLE sees PC=0x102, fetch_fault=1, no RAM_enable pulse.
- Stall and reset abort: stall=1 keeps RAM_enable=0 indefinitely; reset asserted in WAIT, then MFC=1 → no IR update, ir_valid=0, PC=RESET_PC.
